// File: rtl/oc2_pkg.sv
// Shared widths and index types for the oc2 pipeline blocks.
package oc2_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NREGS  = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/issue_y_scoreboard.sv
// Pending-write bitmap for the Y pipe plus the RAW/WAW hazard check feeding id_is_ready.
module issue_y_scoreboard
  import oc2_pkg::*;
#(
  parameter int NREGS = oc2_pkg::NREGS
) (
  input  logic     clock,
  input  logic     reset,
  input  reg_idx_t rs_i,
  input  reg_idx_t rt_i,
  input  reg_idx_t rd_i,
  input  logic     writereg_i,
  input  logic     fire_i,
  input  reg_idx_t wb_rd_i,
  input  logic     wb_we_i,
  output logic     ready_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // A writeback landing this cycle resolves the hazard because its value is bypassed.
  function automatic logic hazard(input logic [NREGS-1:0] pend, input reg_idx_t src,
                                  input logic wb_we, input reg_idx_t wb_rd);
    hazard = pend[src] && !(wb_we && (wb_rd == src));
  endfunction

  always_comb begin
    ready_o = !(hazard(pending_q, rs_i, wb_we_i, wb_rd_i) ||
                hazard(pending_q, rt_i, wb_we_i, wb_rd_i) ||
                (writereg_i && hazard(pending_q, rd_i, wb_we_i, wb_rd_i)));
  end

  // Set is applied after clear so a new in-flight write to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_we_i) pending_d[wb_rd_i] = 1'b0;
    if (fire_i && writereg_i && (rd_i != '0)) pending_d[rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: rtl/issue_y.sv
// Y-pipe issue stage: hazard stall, writeback bypass operand select, one-cycle issue register.
module issue_y
  import oc2_pkg::*;
#(
  parameter int DATA_W = oc2_pkg::DATA_W,
  parameter int NREGS  = oc2_pkg::NREGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_is_valid,
  output logic              id_is_ready,
  input  logic [REG_W-1:0]  id_is_rs,
  input  logic [REG_W-1:0]  id_is_rt,
  input  logic [REG_W-1:0]  id_is_regdest,
  input  logic              id_is_writereg,
  output logic [REG_W-1:0]  is_rf_addra,
  output logic [REG_W-1:0]  is_rf_addrb,
  input  logic [DATA_W-1:0] rf_is_dataa,
  input  logic [DATA_W-1:0] rf_is_datab,
  input  logic [REG_W-1:0]  y_wb_regdest,
  input  logic              y_wb_writereg,
  input  logic [DATA_W-1:0] y_wb_wbvalue,
  output logic              is_y_valid,
  output logic [DATA_W-1:0] is_y_rega,
  output logic [DATA_W-1:0] is_y_regb,
  output logic [REG_W-1:0]  is_y_regdest,
  output logic              is_y_writereg
);

  logic              fire;
  logic [DATA_W-1:0] opa, opb;
  logic              valid_q, valid_d;
  logic              writereg_q, writereg_d;
  logic [REG_W-1:0]  regdest_q, regdest_d;
  logic [DATA_W-1:0] rega_q, rega_d;
  logic [DATA_W-1:0] regb_q, regb_d;

  function automatic logic [DATA_W-1:0] sel_operand(input reg_idx_t idx,
                                                    input logic [DATA_W-1:0] rf,
                                                    input logic wb_we, input reg_idx_t wb_rd,
                                                    input logic [DATA_W-1:0] wb_val);
    if (idx == '0)                     sel_operand = '0;
    else if (wb_we && (wb_rd == idx))  sel_operand = wb_val;
    else                               sel_operand = rf;
  endfunction

  assign is_rf_addra = id_is_rs;
  assign is_rf_addrb = id_is_rt;
  assign fire        = id_is_valid && id_is_ready;

  issue_y_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .rs_i       (id_is_rs),
    .rt_i       (id_is_rt),
    .rd_i       (id_is_regdest),
    .writereg_i (id_is_writereg),
    .fire_i     (fire),
    .wb_rd_i    (y_wb_regdest),
    .wb_we_i    (y_wb_writereg),
    .ready_o    (id_is_ready)
  );

  // Execute_Y never stalls, so every cycle loads either an instruction or a zeroed bubble.
  always_comb begin
    opa        = sel_operand(id_is_rs, rf_is_dataa, y_wb_writereg, y_wb_regdest, y_wb_wbvalue);
    opb        = sel_operand(id_is_rt, rf_is_datab, y_wb_writereg, y_wb_regdest, y_wb_wbvalue);
    valid_d    = fire;
    writereg_d = fire && id_is_writereg;
    regdest_d  = fire ? id_is_regdest : '0;
    rega_d     = fire ? opa : '0;
    regb_d     = fire ? opb : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      writereg_q <= 1'b0;
      regdest_q  <= '0;
      rega_q     <= '0;
      regb_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      writereg_q <= writereg_d;
      regdest_q  <= regdest_d;
      rega_q     <= rega_d;
      regb_q     <= regb_d;
    end
  end

  assign is_y_valid    = valid_q;
  assign is_y_writereg = writereg_q;
  assign is_y_regdest  = regdest_q;
  assign is_y_rega     = rega_q;
  assign is_y_regb     = regb_q;

endmodule

// File: tb/tb_issue_y.sv
// Directed bench for issue_y: sequential vector table plus hand-written reset sequence.
module tb_issue_y;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_is_valid;
  logic        id_is_ready;
  logic [4:0]  id_is_rs, id_is_rt, id_is_regdest;
  logic        id_is_writereg;
  logic [4:0]  is_rf_addra, is_rf_addrb;
  logic [31:0] rf_is_dataa, rf_is_datab;
  logic [4:0]  y_wb_regdest;
  logic        y_wb_writereg;
  logic [31:0] y_wb_wbvalue;
  logic        is_y_valid;
  logic [31:0] is_y_rega, is_y_regb;
  logic [4:0]  is_y_regdest;
  logic        is_y_writereg;

  int tests = 0;
  int fails = 0;

  issue_y dut (
    .clock(clock), .reset(reset),
    .id_is_valid(id_is_valid), .id_is_ready(id_is_ready),
    .id_is_rs(id_is_rs), .id_is_rt(id_is_rt), .id_is_regdest(id_is_regdest),
    .id_is_writereg(id_is_writereg),
    .is_rf_addra(is_rf_addra), .is_rf_addrb(is_rf_addrb),
    .rf_is_dataa(rf_is_dataa), .rf_is_datab(rf_is_datab),
    .y_wb_regdest(y_wb_regdest), .y_wb_writereg(y_wb_writereg), .y_wb_wbvalue(y_wb_wbvalue),
    .is_y_valid(is_y_valid), .is_y_rega(is_y_rega), .is_y_regb(is_y_regb),
    .is_y_regdest(is_y_regdest), .is_y_writereg(is_y_writereg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic        wr;
    logic [31:0] rfa, rfb;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbval;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_rd;
    logic        e_wr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic wr,
                              logic [31:0] rfa, logic [31:0] rfb,
                              logic wbwe, logic [4:0] wbrd, logic [31:0] wbval,
                              logic e_ready, logic e_valid, logic [31:0] e_a, logic [31:0] e_b,
                              logic [4:0] e_rd, logic e_wr);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.wr = wr; t.rfa = rfa; t.rfb = rfb;
    t.wbwe = wbwe; t.wbrd = wbrd; t.wbval = wbval;
    t.e_ready = e_ready; t.e_valid = e_valid; t.e_a = e_a; t.e_b = e_b;
    t.e_rd = e_rd; t.e_wr = e_wr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wr, input logic [31:0] rfa,
                       input logic [31:0] rfb, input logic wbwe, input logic [4:0] wbrd,
                       input logic [31:0] wbval);
    id_is_valid = v; id_is_rs = rs; id_is_rt = rt; id_is_regdest = rd; id_is_writereg = wr;
    rf_is_dataa = rfa; rf_is_datab = rfb;
    y_wb_writereg = wbwe; y_wb_regdest = wbrd; y_wb_wbvalue = wbval;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic wr);
    check({tag, ".valid"},    {31'd0, is_y_valid},    {31'd0, v});
    check({tag, ".rega"},     is_y_rega,              a);
    check({tag, ".regb"},     is_y_regb,              b);
    check({tag, ".regdest"},  {27'd0, is_y_regdest},  {27'd0, rd});
    check({tag, ".writereg"}, {31'd0, is_y_writereg}, {31'd0, wr});
  endtask

  initial begin
    // Rows run back to back; the pending bitmap carries state from row to row.
    vecs[0]  = mk(1, 1, 2, 3, 1, 32'h11, 32'h22, 0, 0, 0,        1, 1, 32'h11, 32'h22, 3, 1);
    vecs[1]  = mk(1, 3, 0, 0, 0, 32'h55, 32'h66, 0, 0, 0,        0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 3, 0, 0, 0, 32'h55, 32'h66, 0, 0, 0,        0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 3, 0, 0, 0, 32'h55, 32'h66, 1, 3, 32'hABCD, 1, 1, 32'hABCD, 0, 0, 0);
    vecs[4]  = mk(1, 1, 2, 3, 1, 32'h1, 32'h2, 0, 0, 0,          1, 1, 32'h1, 32'h2, 3, 1);
    vecs[5]  = mk(1, 0, 0, 3, 1, 32'h1, 32'h2, 0, 0, 0,          0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 3, 1, 32'h1, 32'h2, 1, 3, 32'h9,      1, 1, 0, 0, 3, 1);
    vecs[7]  = mk(1, 3, 0, 0, 0, 32'h5, 32'h6, 0, 0, 0,          0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 32'h5, 32'h6, 1, 3, 32'h7,      1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    vecs[11] = mk(1, 1, 2, 4, 1, 32'h100, 32'h200, 0, 0, 0,      1, 1, 32'h100, 32'h200, 4, 1);
    vecs[12] = mk(1, 1, 2, 5, 1, 32'h101, 32'h201, 0, 0, 0,      1, 1, 32'h101, 32'h201, 5, 1);
    vecs[13] = mk(1, 1, 2, 6, 1, 32'h102, 32'h202, 0, 0, 0,      1, 1, 32'h102, 32'h202, 6, 1);
    vecs[14] = mk(1, 4, 5, 0, 0, 32'h1, 32'h2, 0, 0, 0,          0, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 4, 0, 0, 0, 32'h0, 32'h0, 1, 4, 32'h44,     1, 1, 32'h44, 0, 0, 0);
    vecs[16] = mk(1, 9, 0, 0, 0, 32'h77, 32'h0, 1, 9, 32'h99,    1, 1, 32'h99, 0, 0, 0);
    vecs[17] = mk(1, 0, 5, 0, 0, 32'h0, 32'h3, 1, 5, 32'h55,     1, 1, 0, 32'h55, 0, 0);
    vecs[18] = mk(1, 0, 0, 6, 0, 32'h0, 32'h0, 0, 0, 0,          1, 1, 0, 0, 6, 0);
    vecs[19] = mk(1, 0, 0, 6, 1, 32'h0, 32'h0, 0, 0, 0,          0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    check("reset.ready", {31'd0, id_is_ready}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wr, vecs[i].rfa, vecs[i].rfb,
            vecs[i].wbwe, vecs[i].wbrd, vecs[i].wbval);
      #1;
      check($sformatf("v%0d.ready", i), {31'd0, id_is_ready}, {31'd0, vecs[i].e_ready});
      check($sformatf("v%0d.addra", i), {27'd0, is_rf_addra}, {27'd0, vecs[i].rs});
      @(posedge clock);
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_a, vecs[i].e_b,
                 vecs[i].e_rd, vecs[i].e_wr);
    end

    // Mid-stream reset: r6 and r7 pending and an issue in the output register.
    drive(1, 1, 2, 7, 1, 32'hA, 32'hB, 0, 0, 0);
    @(posedge clock);
    #1;
    check_outs("r7issue", 1, 32'hA, 32'hB, 7, 1);
    drive(1, 7, 6, 0, 0, 32'h70, 32'h60, 0, 0, 0);
    #1;
    check("r7stall.ready", {31'd0, id_is_ready}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check_outs("midreset", 0, 0, 0, 0, 0);
    check("midreset.ready", {31'd0, id_is_ready}, 32'd1);
    @(posedge clock);
    #1;
    check_outs("midreset.hold", 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check("postreset.ready", {31'd0, id_is_ready}, 32'd1);
    @(posedge clock);
    #1;
    check_outs("postreset", 1, 32'h70, 32'h60, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_y.md
ISSUE_Y -- requirements
Module: issue_y

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 Parameters SHALL be: DATA_W, 32, operand/result width; NREGS, 32, architectural register count (5-bit index).
REQ-003 Ports SHALL be exactly:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- id_is_valid  in  1  decode offers an instruction
- id_is_ready  out  1  issue accepts the instruction this cycle
- id_is_rs  in  5  source A register index
- id_is_rt  in  5  source B register index
- id_is_regdest  in  5  destination register index
- id_is_writereg  in  1  instruction writes regdest
- is_rf_addra  out  5  register-file read address A (= id_is_rs)
- is_rf_addrb  out  5  register-file read address B (= id_is_rt)
- rf_is_dataa  in  32  register-file read data A (combinational)
- rf_is_datab  in  32  register-file read data B (combinational)
- y_wb_regdest  in  5  Y-pipe writeback destination
- y_wb_writereg  in  1  Y-pipe writeback valid
- y_wb_wbvalue  in  32  Y-pipe writeback value
- is_y_valid  out  1  issued instruction present
- is_y_rega  out  32  operand A to Execute_Y
- is_y_regb  out  32  operand B to Execute_Y
- is_y_regdest  out  5  destination to Execute_Y
- is_y_writereg  out  1  write-enable to Execute_Y

Function
REQ-004 The block SHALL keep a 32-bit pending bitmap; bit r set means an issued, not-yet-written-back write to register r.
REQ-005 Bit 0 SHALL never be set; an operand index 0 SHALL read as 0 regardless of rf data.
REQ-006 Hazard(src) SHALL be pending[src] AND NOT (y_wb_writereg AND y_wb_regdest == src).
- id_is_ready SHALL be NOT (hazard(rs) OR hazard(rt) OR (id_is_writereg AND hazard(regdest))); combinational, independent of id_is_valid.
REQ-007 Operand selection SHALL be, per source: 0 if index 0; y_wb_wbvalue if y_wb_writereg and y_wb_regdest equal the index; else rf data.
REQ-008 A fire is id_is_valid AND id_is_ready; on fire, outputs SHALL register next edge: is_y_valid=1, selected operands, regdest, writereg (latency 1 cycle).
REQ-009 Without fire, the next edge SHALL register a bubble: is_y_valid=0, is_y_writereg=0, is_y_regdest=0, is_y_rega=is_y_regb=0.
REQ-010 Execute_Y never stalls; the issue output register SHALL update every cycle.
REQ-011 On a fire with id_is_writereg=1 and regdest!=0, pending[regdest] SHALL be set at the next edge.
REQ-012 On y_wb_writereg=1, pending[y_wb_regdest] SHALL be cleared at the next edge.
REQ-013 Simultaneous set and clear of the same bit SHALL resolve to set (new write in flight).
REQ-014 WAW SHALL be prevented by stall (REQ-006); at most one in-flight write per register.
REQ-015 Writeback for a register not pending SHALL be ignored by the bitmap (no error).

Reset
REQ-016 While reset is high: pending=0, is_y_valid=0, is_y_writereg=0, is_y_regdest=0, is_y_rega=is_y_regb=0.
REQ-017 Reset asserted mid-stream SHALL drop the issue register contents and all pending bits; id_is_ready SHALL be 1 after reset (combinational, no pending).

Structure
REQ-018 DATA_W, REG_W=5 and NREGS SHALL live in the shared oc2 package.
REQ-019 The pending bitmap and hazard logic SHALL be one sub-module, issue_y_scoreboard; operand mux and output register stay in issue_y.

Verification
REQ-020 Issue rs=1,rt=2,rd=3,wr=1 with rf=0x11/0x22 -> next cycle is_y_valid=1, rega=0x11, regb=0x22, regdest=3; pending[3]=1.
REQ-021 With pending[3], offer rs=3 -> id_is_ready=0 and bubbles until y_wb regdest=3 value 0xABCD; in that cycle ready=1 and is_y_rega=0xABCD next cycle.
REQ-022 Offer rd=3 (WAW) while pending[3] -> stall; same cycle as wb of r3 -> fire, pending[3] remains 1.
REQ-023 rs=0,rt=0,rd=0,wr=1, rf returns 0xFFFFFFFF -> rega=regb=0, pending unchanged, ready stays 1.
REQ-024 Back-to-back independent instructions (rd=4,5,6) -> three consecutive valid issues, no stall cycles.
REQ-025 Assert reset with pending[7]=1 and is_y_valid=1 -> all outputs 0, pending=0, rs=7 issues immediately after release.
